zsync50hz_gen: RTL and testbench
================================

Name: zsync50hz_gen

Overview:
- Source side of the 50Hz sync interface: turns the raw external mains-sync input into a clean one-cycle sync pulse for the tick/trigger chain.
- Synchronises and debounces the raw input, then validates each edge against the 20mS nominal period.
- Flywheels over missing edges and falls back to an internal free-running 50Hz generator when the external sync is absent.
- Also reports lock status, the measured period and a miss count for diagnostics.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser.
- DEBOUNCE_CNT, 1000, consecutive stable cycles needed to change the filtered level (10uS at 100MHz).
- NOM_PERIOD, 2000000, nominal sync period in cycles (20mS).
- TOL, 100000, allowed period deviation in cycles (±1mS).
- LOCK_CNT, 3, consecutive in-window periods needed to reach lock.
- FLY_MAX, 2, consecutive flywheel pulses allowed before lock is dropped.
- LOSS_CNT, 4000000, ACQUIRE timeout in cycles (40mS).

Ports:
- iClk  in  1  100MHz system clock.
- iRst  in  1  synchronous, active-high reset.
- iSyncRaw  in  1  raw asynchronous external 50Hz sync.
- iForceFree  in  1  level; forces the internal generator and ignores the external sync.
- oSync50Hz  out  1  one-cycle sync pulse, registered.
- oLocked  out  1  high in LOCKED.
- oSyncLost  out  1  high in FREE.
- oPeriodCnt  out  24  last measured external period in cycles.
- oMissCnt  out  8  saturating count of missing or rejected edges.

Behaviour:
- Reset: one clock, iRst synchronous active-high. While iRst is high, all outputs are 0 except oSyncLost=1. State=FREE, period counter P=0, good=0, fly=0, filtered level=0, synchroniser flops=0.
- Filter: the filtered level changes only after the synchronised input has differed from it for DEBOUNCE_CNT consecutive cycles. A single disagreeing sample restarts the count.
- Edge: "edge" means a rising edge of the filtered level. Raw rising edge to oSync50Hz latency is SYNC_STAGES+DEBOUNCE_CNT+1 cycles, exactly.
- Period counter P: resets to 0 on every emitted pulse; otherwise increments, saturating at 2^24-1. Measured period M=P+1 on the edge cycle.
- Window: M in [NOM_PERIOD-TOL, NOM_PERIOD+TOL]. Early: M<NOM_PERIOD-TOL. Late: M>NOM_PERIOD+TOL.
- oPeriodCnt <= M on every accepted external edge.
- oMissCnt increments at the events marked "miss" below and saturates at 255.
- FREE:
  - When M==NOM_PERIOD with no edge: pulse, P<=0.
  - On an edge: pulse, P<=0, good<=0, go to ACQUIRE.
- ACQUIRE:
  - In-window edge: pulse, P<=0, good++. When good reaches LOCK_CNT, go to LOCKED with fly<=0.
  - Early edge: ignored; miss.
  - Late edge: pulse, P<=0, good<=0.
  - M==LOSS_CNT with no edge: pulse, P<=0, miss, go to FREE.
- LOCKED:
  - In-window edge: pulse, P<=0, fly<=0.
  - Early edge: ignored; miss.
  - M==NOM_PERIOD+TOL with no edge (flywheel): pulse, P<=0, miss, fly++. When fly reaches FLY_MAX, go to FREE.
- Simultaneous events:
  - An edge on the flywheel/timeout cycle is treated as an edge; no miss.
  - iForceFree has priority over everything. While it is high, state is held in FREE, edges are ignored (no miss), and internal pulses continue on the FREE cadence. On release, normal FREE rules apply.
- Pulse spacing: oSync50Hz never asserts on two consecutive cycles.
- Reset mid-operation: the first internal pulse occurs NOM_PERIOD cycles after iRst deasserts.

Test Plan (NOM_PERIOD=1000, TOL=50, DEBOUNCE_CNT=4, SYNC_STAGES=2, LOCK_CNT=3, FLY_MAX=2, LOSS_CNT=2000):
- Reset, then iSyncRaw=0 -> oSyncLost=1, oSync50Hz pulses 1000 cycles after reset release and every 1000 cycles thereafter; oMissCnt=0.
- Raw edges every 1000 cycles -> each pulse arrives 7 cycles after its raw edge; oLocked=1 after the 4th edge (3 in-window periods); oPeriodCnt=1000.
- Locked, then one edge omitted -> flywheel pulse at M=1050; oMissCnt=1; still locked. Next edge at the nominal time is in-window (M=950).
- Locked, then sync removed -> flywheel pulses at 1050 and 2100 after the last edge; oLocked=0 and oSyncLost=1 after the second; FREE pulses every 1000 after that.
- 3-cycle glitch on iSyncRaw -> no pulse. Edge at M=500 while locked -> ignored, oMissCnt+1, period unaffected.
- iForceFree=1 with a valid external sync -> only internal 1000-cycle pulses, oMissCnt unchanged. iRst mid-ACQUIRE -> all outputs return to reset values.

Source files
------------

// File: rtl/zsync50hz_gen_if.sv
// Signal bundle between the 50Hz sync source and its consumer.
// The master side is the sync generator; the slave side drives the raw input and force control.
interface zsync50hz_gen_if;
    logic        iSyncRaw;
    logic        iForceFree;
    logic        oSync50Hz;
    logic        oLocked;
    logic        oSyncLost;
    logic [23:0] oPeriodCnt;
    logic [7:0]  oMissCnt;

    modport master (
        input  iSyncRaw,
        input  iForceFree,
        output oSync50Hz,
        output oLocked,
        output oSyncLost,
        output oPeriodCnt,
        output oMissCnt
    );

    modport slave (
        output iSyncRaw,
        output iForceFree,
        input  oSync50Hz,
        input  oLocked,
        input  oSyncLost,
        input  oPeriodCnt,
        input  oMissCnt
    );
endinterface

// File: rtl/zsync50hz_gen.sv
// 50Hz sync source: synchronise, debounce and period-validate the external mains sync,
// flywheel over missing edges and fall back to an internal free-running generator.
module zsync50hz_gen #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned NOM_PERIOD   = 2000000,
    parameter int unsigned TOL          = 100000,
    parameter int unsigned LOCK_CNT     = 3,
    parameter int unsigned FLY_MAX      = 2,
    parameter int unsigned LOSS_CNT     = 4000000
) (
    input  logic           iClk,
    input  logic           iRst,
    zsync50hz_gen_if.master bus
);
    typedef enum logic [1:0] {StFree, StAcquire, StLocked} state_e;

    localparam int unsigned DebW  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [23:0] PMax  = '1;
    localparam int unsigned WinLo = NOM_PERIOD - TOL;
    localparam int unsigned WinHi = NOM_PERIOD + TOL;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DebW-1:0]        deb_q, deb_d;
    logic                   filt_q, filt_d, filt_prev_q;
    logic [23:0]            p_q, p_d, m;
    logic [23:0]            period_q, period_d;
    logic [7:0]             good_q, good_d, fly_q, fly_d, miss_q, miss_d;
    logic                   pulse_q, pulse_d;
    logic                   synced, edge_w, want, miss_inc, early, late;

    // Synchroniser and debounce filter
    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(bus.iSyncRaw);
        synced = sync_q[SYNC_STAGES-1];
        filt_d = filt_q;
        deb_d  = '0;
        if (synced != filt_q) begin
            if (32'(deb_q) + 32'd1 >= DEBOUNCE_CNT) begin
                filt_d = synced;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    assign edge_w = filt_q & ~filt_prev_q;
    assign m      = (p_q == PMax) ? PMax : p_q + 24'd1;
    assign early  = 32'(m) < WinLo;
    assign late   = 32'(m) > WinHi;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        fly_d    = fly_q;
        period_d = period_q;
        want     = 1'b0;
        miss_inc = 1'b0;
        if (bus.iForceFree) begin
            state_d = StFree;
            want    = (32'(m) == NOM_PERIOD);
        end else begin
            unique case (state_q)
                StFree: begin
                    if (edge_w) begin
                        want     = 1'b1;
                        good_d   = '0;
                        period_d = m;
                        state_d  = StAcquire;
                    end else if (32'(m) == NOM_PERIOD) begin
                        want = 1'b1;
                    end
                end
                StAcquire: begin
                    if (edge_w) begin
                        if (early) begin
                            miss_inc = 1'b1;
                        end else if (late) begin
                            want     = 1'b1;
                            good_d   = '0;
                            period_d = m;
                        end else begin
                            want     = 1'b1;
                            good_d   = good_q + 8'd1;
                            period_d = m;
                            if (32'(good_q) + 32'd1 == LOCK_CNT) begin
                                state_d = StLocked;
                                fly_d   = '0;
                            end
                        end
                    end else if (32'(m) == LOSS_CNT) begin
                        want     = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = StFree;
                    end
                end
                StLocked: begin
                    if (edge_w) begin
                        if (early) begin
                            miss_inc = 1'b1;
                        end else begin
                            want     = 1'b1;
                            fly_d    = '0;
                            period_d = m;
                        end
                    end else if (32'(m) == WinHi) begin
                        want     = 1'b1;
                        miss_inc = 1'b1;
                        fly_d    = fly_q + 8'd1;
                        if (32'(fly_q) + 32'd1 == FLY_MAX) begin
                            state_d = StFree;
                        end
                    end
                end
                default: state_d = StFree;
            endcase
        end
        // A pulse request right after a pulse still restarts the period but is not emitted
        pulse_d = want & ~pulse_q;
        p_d     = want ? 24'd0 : m;
        miss_d  = (miss_inc && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= StFree;
            sync_q      <= '0;
            deb_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            p_q         <= '0;
            period_q    <= '0;
            good_q      <= '0;
            fly_q       <= '0;
            miss_q      <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            p_q         <= p_d;
            period_q    <= period_d;
            good_q      <= good_d;
            fly_q       <= fly_d;
            miss_q      <= miss_d;
            pulse_q     <= pulse_d;
        end
    end

    assign bus.oSync50Hz  = pulse_q;
    assign bus.oLocked    = (state_q == StLocked);
    assign bus.oSyncLost  = (state_q == StFree);
    assign bus.oPeriodCnt = period_q;
    assign bus.oMissCnt   = miss_q;
endmodule

// File: tb/tb_zsync50hz_gen.sv
// Bench for zsync50hz_gen: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_zsync50hz_gen;
    localparam int SYNC = 2, DEB = 4, NOM = 1000, TOL = 50, LOCK = 3, FLYMAX = 2, LOSS = 2000;
    localparam int HistLen = SYNC + DEB;
    localparam int MFree = 0, MAcq = 1, MLocked = 2;

    logic clk = 1'b0;
    logic rst;
    zsync50hz_gen_if bus ();

    zsync50hz_gen #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CNT(DEB),
        .NOM_PERIOD  (NOM),
        .TOL         (TOL),
        .LOCK_CNT    (LOCK),
        .FLY_MAX     (FLYMAX),
        .LOSS_CNT    (LOSS)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: filtered level from raw sample history, period from pulse timestamps
    bit raw_hist[$];
    bit f_now, f_old, edge_seen, flip, want, miss;
    int st, last_pulse, good, fly, m;
    int e_pulse, e_period, e_miss;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                raw_hist.delete();
                for (int i = 0; i < HistLen; i++) raw_hist.push_back(1'b0);
                f_now = 0; f_old = 0;
                st = MFree; last_pulse = cyc; good = 0; fly = 0;
                e_pulse = 0; e_period = 0; e_miss = 0;
            end else begin
                raw_hist.push_back(bus.iSyncRaw);
                void'(raw_hist.pop_front());
                edge_seen = f_now && !f_old;
                flip = 1;
                for (int j = SYNC; j < SYNC + DEB; j++)
                    if (raw_hist[HistLen-1-j] == f_now) flip = 0;
                f_old = f_now;
                if (flip) f_now = !f_now;
                m = cyc - last_pulse;
                want = 0; miss = 0;
                if (bus.iForceFree) begin
                    st = MFree;
                    want = (m == NOM);
                end else begin
                    case (st)
                        MFree: begin
                            if (edge_seen) begin
                                want = 1; good = 0; e_period = m; st = MAcq;
                            end else if (m == NOM) want = 1;
                        end
                        MAcq: begin
                            if (edge_seen) begin
                                if (m < NOM - TOL) miss = 1;
                                else if (m > NOM + TOL) begin
                                    want = 1; good = 0; e_period = m;
                                end else begin
                                    want = 1; good++; e_period = m;
                                    if (good == LOCK) begin st = MLocked; fly = 0; end
                                end
                            end else if (m == LOSS) begin
                                want = 1; miss = 1; st = MFree;
                            end
                        end
                        default: begin
                            if (edge_seen) begin
                                if (m < NOM - TOL) miss = 1;
                                else begin want = 1; fly = 0; e_period = m; end
                            end else if (m == NOM + TOL) begin
                                want = 1; miss = 1; fly++;
                                if (fly == FLYMAX) st = MFree;
                            end
                        end
                    endcase
                end
                if (miss && e_miss < 255) e_miss++;
                e_pulse = (want && e_pulse == 0) ? 1 : 0;
                if (want) last_pulse = cyc;
            end
            @(negedge clk);
            chk("sync_pulse", bus.oSync50Hz, e_pulse);
            chk("locked", bus.oLocked, st == MLocked);
            chk("sync_lost", bus.oSyncLost, st == MFree);
            chk("period", bus.oPeriodCnt, e_period);
            chk("miss", bus.oMissCnt, e_miss);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.oSync50Hz && n < 1200);
    endtask

    // Raw high for 100 cycles; call spans n cycles; lat = cycles until first pulse, -1 if none
    task automatic edge_then(input int n, output int lat);
        lat = -1;
        bus.iSyncRaw = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 100) bus.iSyncRaw = 1'b0;
            if (bus.oSync50Hz && lat < 0) lat = i;
        end
    endtask

    int lat, n;

    initial begin
        rst = 1'b1;
        bus.iSyncRaw = 1'b0;
        bus.iForceFree = 1'b0;
        wait_cyc(5);
        chk("rst_lost", bus.oSyncLost, 1);
        chk("rst_period", bus.oPeriodCnt, 0);
        rst = 1'b0;

        // Free-running cadence from reset release
        wait_pulse(n);
        chk("first_free_pulse", n, 1000);
        wait_pulse(n);
        chk("second_free_pulse", n, 1000);
        chk("free_miss", bus.oMissCnt, 0);
        wait_cyc(300);

        // Acquire and lock on nominal external edges
        for (int k = 1; k <= 6; k++) begin
            edge_then(1000, lat);
            chk($sformatf("edge%0d_latency", k), lat, 7);
            if (k == 4) chk("locked_after_4", bus.oLocked, 1);
        end
        chk("locked_period", bus.oPeriodCnt, 1000);

        // One missing edge: flywheel, still locked, next edge in window
        wait_cyc(1000);
        chk("fly_miss", bus.oMissCnt, 1);
        chk("fly_locked", bus.oLocked, 1);
        edge_then(1000, lat);
        chk("post_fly_latency", lat, 7);
        chk("post_fly_period", bus.oPeriodCnt, 950);

        // Glitch rejected, early edge ignored
        edge_then(250, lat);
        bus.iSyncRaw = 1'b1;
        wait_cyc(3);
        bus.iSyncRaw = 1'b0;
        wait_cyc(247);
        edge_then(500, lat);
        chk("early_no_pulse", lat, -1);
        chk("early_miss", bus.oMissCnt, 2);
        edge_then(1000, lat);
        chk("after_early_latency", lat, 7);
        chk("after_early_period", bus.oPeriodCnt, 1000);
        chk("after_early_locked", bus.oLocked, 1);

        // Sync removed: two flywheels then free
        wait_cyc(1000);
        chk("loss_fly1_locked", bus.oLocked, 1);
        chk("loss_fly1_miss", bus.oMissCnt, 3);
        wait_cyc(200);
        chk("loss_unlocked", bus.oLocked, 0);
        chk("loss_lost", bus.oSyncLost, 1);
        chk("loss_miss", bus.oMissCnt, 4);
        wait_cyc(2500);

        // Forced free-run ignores a valid external sync
        bus.iForceFree = 1'b1;
        for (int k = 0; k < 4; k++) edge_then(1000, lat);
        chk("force_miss", bus.oMissCnt, 4);
        chk("force_lost", bus.oSyncLost, 1);
        bus.iForceFree = 1'b0;
        wait_cyc(10);

        // Acquire timeout back to free
        edge_then(300, lat);
        chk("acq_entered", bus.oSyncLost, 0);
        wait_cyc(1800);
        chk("acq_timeout_lost", bus.oSyncLost, 1);
        chk("acq_timeout_miss", bus.oMissCnt, 5);

        // Reset mid-acquire
        edge_then(1000, lat);
        edge_then(500, lat);
        chk("mid_acq_lost", bus.oSyncLost, 0);
        chk("mid_acq_locked", bus.oLocked, 0);
        rst = 1'b1;
        wait_cyc(3);
        chk("mid_rst_pulse", bus.oSync50Hz, 0);
        chk("mid_rst_lost", bus.oSyncLost, 1);
        chk("mid_rst_miss", bus.oMissCnt, 0);
        chk("mid_rst_period", bus.oPeriodCnt, 0);
        rst = 1'b0;
        wait_pulse(n);
        chk("post_rst_first_pulse", n, 1000);
        wait_cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
